// File: rtl/command_credit_scheduler_if.sv
// Command line type and the scheduler's bus interface. The scheduler connects
// through the master modport; the command buffers/PSL side uses the slave modport.
package command_credit_scheduler_pkg;

  // CAPI command codes carried on the command port; INVALID marks an idle slot.
  typedef enum logic [12:0] {
    INVALID    = 13'h0000,
    RESTART    = 13'h0001,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60
  } command_type_t;

  typedef struct packed {
    logic          valid;
    logic [7:0]    cmd;
    command_type_t command;
    logic [63:0]   address;
    logic [11:0]   size;
  } CommandBufferLine;

  localparam CommandBufferLine COMMAND_BUFFER_LINE_IDLE = '{
    valid:   1'b0,
    cmd:     8'h00,
    command: INVALID,
    address: 64'h0,
    size:    12'h0
  };

endpackage

interface command_credit_scheduler_if #(
  parameter int NUM_REQUESTS = 4,
  parameter int CREDIT_WIDTH = 8
);
  import command_credit_scheduler_pkg::*;

  logic                                 enabled_in;
  logic [CREDIT_WIDTH-1:0]              credit_init;
  logic                                 response_valid;
  CommandBufferLine [NUM_REQUESTS-1:0]  command_buffer_in;
  logic [NUM_REQUESTS-1:0]              requests;
  CommandBufferLine                     command_arbiter_out;
  logic [NUM_REQUESTS-1:0]              ready;
  logic [CREDIT_WIDTH-1:0]              credits;
  logic                                 drained;
  logic                                 credit_error;

  modport master (
    input  enabled_in,
    input  credit_init,
    input  response_valid,
    input  command_buffer_in,
    input  requests,
    output command_arbiter_out,
    output ready,
    output credits,
    output drained,
    output credit_error
  );

  modport slave (
    output enabled_in,
    output credit_init,
    output response_valid,
    output command_buffer_in,
    output requests,
    input  command_arbiter_out,
    input  ready,
    input  credits,
    input  drained,
    input  credit_error
  );

endinterface

// File: rtl/command_credit_scheduler.sv
// Credit-aware scheduler sharing the CAPI command port between NUM_REQUESTS buffers.
// Define CMD_SCHED_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (index 0 first).
module command_credit_scheduler
  import command_credit_scheduler_pkg::*;
#(
  parameter int NUM_REQUESTS = 4,
  parameter int CREDIT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       rst,
  command_credit_scheduler_if.master bus
);

  localparam int IDX_W = (NUM_REQUESTS > 1) ? $clog2(NUM_REQUESTS) : 1;
  localparam int SUM_W = IDX_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]              state_reg, state_next;
  logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
  logic [CREDIT_WIDTH-1:0] limit_reg, limit_next;
  logic                    credit_error_reg, credit_error_next;
  CommandBufferLine        out_reg, out_next;

  logic             grant_en;
  logic [IDX_W-1:0] grant_idx;
  logic             at_limit;
  logic             resp_ok;

  genvar gi;

  assign at_limit = (credits_reg == limit_reg);
  assign grant_en = (state_reg == RUN) && (credits_reg != '0) && (|bus.requests);

`ifdef CMD_SCHED_ROUND_ROBIN_EN
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQUESTS - 1);

  logic [IDX_W-1:0]        ptr_reg, ptr_next;
  logic [NUM_REQUESTS-1:0] rot_req;
  logic [IDX_W-1:0]        rot_idx [NUM_REQUESTS];

  // Position gi of the rotated view is requester (ptr + 1 + gi) mod NUM_REQUESTS.
  generate
    for (gi = 0; gi < NUM_REQUESTS; gi++) begin : g_rot
      logic [SUM_W-1:0] sum;
      assign sum = {1'b0, ptr_reg} + SUM_W'(gi + 1);
      assign rot_idx[gi] = (sum >= SUM_W'(NUM_REQUESTS)) ?
                           IDX_W'(sum - SUM_W'(NUM_REQUESTS)) : sum[IDX_W-1:0];
      assign rot_req[gi] = bus.requests[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQUESTS - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant_idx = rot_idx[k];
      end
    end
  end

  assign ptr_next = grant_en ? grant_idx : ptr_reg;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      ptr_reg <= PTR_RESET;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  always_comb begin
    grant_idx = '0;
    for (int k = NUM_REQUESTS - 1; k >= 0; k--) begin
      if (bus.requests[k]) begin
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

  // grant_idx always points at a requester with its bit set, so ready stays one-hot.
  generate
    for (gi = 0; gi < NUM_REQUESTS; gi++) begin : g_ready
      assign bus.ready[gi] = grant_en && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next        = state_reg;
    credits_next      = credits_reg;
    limit_next        = limit_reg;
    credit_error_next = credit_error_reg;
    resp_ok           = 1'b0;
    out_next          = COMMAND_BUFFER_LINE_IDLE;

    case (state_reg)
      IDLE: begin
        credits_next = '0;
        if (bus.response_valid) begin
          credit_error_next = 1'b1;
        end
        if (bus.enabled_in) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        credits_next = bus.credit_init;
        limit_next   = bus.credit_init;
        if (bus.response_valid) begin
          credit_error_next = 1'b1;
        end
        state_next = RUN;
      end
      RUN, DRAIN: begin
        // A response with every credit already home is spurious: flag it and drop it.
        if (bus.response_valid) begin
          if (at_limit) begin
            credit_error_next = 1'b1;
          end else begin
            resp_ok = 1'b1;
          end
        end
        if (grant_en && !resp_ok) begin
          credits_next = credits_reg - CREDIT_WIDTH'(1);
        end else if (!grant_en && resp_ok) begin
          credits_next = credits_reg + CREDIT_WIDTH'(1);
        end

        if (state_reg == RUN) begin
          if (!bus.enabled_in) begin
            state_next = DRAIN;
          end
        end else if (at_limit) begin
          state_next   = IDLE;
          credits_next = '0;
        end else if (bus.enabled_in) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (grant_en) begin
      out_next       = bus.command_buffer_in[grant_idx];
      out_next.valid = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      credits_reg      <= '0;
      limit_reg        <= '0;
      credit_error_reg <= 1'b0;
      out_reg          <= COMMAND_BUFFER_LINE_IDLE;
    end else begin
      state_reg        <= state_next;
      credits_reg      <= credits_next;
      limit_reg        <= limit_next;
      credit_error_reg <= credit_error_next;
      out_reg          <= out_next;
    end
  end

  assign bus.command_arbiter_out = out_reg;
  assign bus.credits             = credits_reg;
  assign bus.drained             = (state_reg == IDLE) || ((state_reg == DRAIN) && at_limit);
  assign bus.credit_error        = credit_error_reg;

endmodule

// File: tb/tb_command_credit_scheduler.sv
// Bench for command_credit_scheduler: vector table, directed corner sequences and
// randomized traffic checked against an outstanding-count reference model.
module tb_command_credit_scheduler;
  import command_credit_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  command_credit_scheduler_if #(.NUM_REQUESTS(N), .CREDIT_WIDTH(CW)) bus ();

  command_credit_scheduler #(.NUM_REQUESTS(N), .CREDIT_WIDTH(CW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  CommandBufferLine lines [N];

  // Reference model: phase, limit and number of commands still in flight.
  typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DRAIN} mphase_t;
  mphase_t          m_phase;
  int               m_out, m_limit, m_last;
  bit               m_err;
  CommandBufferLine m_exp_out;

  int              p_pick;
  logic            p_en, p_resp;
  logic [CW-1:0]   p_init;
  logic [N-1:0]    p_req;

  typedef struct {
    logic       en;
    logic [7:0] init;
    logic [3:0] req;
    logic       resp;
    logic [3:0] rdy_rr;
    logic [3:0] rdy_fp;
    int         cr;
    logic       dr;
    int         src_rr;
    int         src_fp;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic CommandBufferLine idle_line();
    CommandBufferLine l;
    l.valid   = 1'b0;
    l.cmd     = 8'h00;
    l.command = INVALID;
    l.address = 64'h0;
    l.size    = 12'h0;
    return l;
  endfunction

  function automatic CommandBufferLine issued(input int i);
    CommandBufferLine l;
    l = lines[i];
    l.valid = 1'b1;
    return l;
  endfunction

  function automatic CommandBufferLine rand_line();
    CommandBufferLine l;
    l.valid = 1'($urandom % 2);
    l.cmd   = 8'($urandom);
    case ($urandom % 3)
      0:       l.command = READ_CL_NA;
      1:       l.command = WRITE_NA;
      default: l.command = READ_CL_S;
    endcase
    l.address = {$urandom, $urandom};
    l.size    = 12'($urandom_range(1, 128));
    return l;
  endfunction

  function automatic int m_credits();
    return (m_phase == M_RUN || m_phase == M_DRAIN) ? (m_limit - m_out) : 0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] req);
    if (m_phase != M_RUN || m_credits() == 0 || req == '0) return -1;
`ifdef CMD_SCHED_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (req[idx]) return idx;
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_phase   = M_IDLE;
    m_out     = 0;
    m_limit   = 0;
    m_last    = N - 1;
    m_err     = 1'b0;
    m_exp_out = idle_line();
  endtask

  // Drive one cycle's inputs at the falling edge and compare outputs against the model.
  task automatic apply(input logic en, input logic [CW-1:0] init,
                       input logic [N-1:0] req, input logic resp);
    logic [N-1:0] er;
    @(negedge clock);
    bus.enabled_in     = en;
    bus.credit_init    = init;
    bus.requests       = req;
    bus.response_valid = resp;
    for (int i = 0; i < N; i++) bus.command_buffer_in[i] = lines[i];
    p_en = en; p_init = init; p_req = req; p_resp = resp;
    #1;
    p_pick = model_pick(req);
    er = '0;
    if (p_pick >= 0) er[p_pick] = 1'b1;
    chk("ready", 128'(bus.ready), 128'(er));
    chk("credits", 128'(bus.credits), 128'(m_credits()));
    chk("drained", 128'(bus.drained),
        128'(m_phase == M_IDLE || (m_phase == M_DRAIN && m_out == 0)));
    chk("credit_error", 128'(bus.credit_error), 128'(m_err));
    chk("cmd_out", 128'(bus.command_arbiter_out), 128'(m_exp_out));
  endtask

  task automatic tick();
    mphase_t old_phase;
    int      old_out;
    bit      g, r_ok;
    @(posedge clock);
    cyc++;
    old_phase = m_phase;
    old_out   = m_out;
    g         = (p_pick >= 0);
    r_ok      = 1'b0;
    m_exp_out = idle_line();
    case (old_phase)
      M_IDLE: begin
        if (p_resp) m_err = 1'b1;
        if (p_en) m_phase = M_LOAD;
      end
      M_LOAD: begin
        if (p_resp) m_err = 1'b1;
        m_limit = int'(p_init);
        m_out   = 0;
        m_phase = M_RUN;
      end
      default: begin
        if (p_resp) begin
          if (old_out == 0) m_err = 1'b1;
          else r_ok = 1'b1;
        end
        m_out = m_out + (g ? 1 : 0) - (r_ok ? 1 : 0);
        if (old_phase == M_RUN) begin
          if (!p_en) m_phase = M_DRAIN;
        end else if (old_out == 0) begin
          m_phase = M_IDLE;
        end else if (p_en) begin
          m_phase = M_RUN;
        end
        if (g) begin
          m_last    = p_pick;
          m_exp_out = issued(p_pick);
          $display("cycle %0d grant idx=%0d addr=%h outstanding=%0d",
                   cyc, p_pick, lines[p_pick].address, m_out);
        end
      end
    endcase
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.enabled_in     = 1'b0;
    bus.response_valid = 1'b0;
    bus.requests       = '0;
    bus.credit_init    = '0;
    model_reset();
    #1;
    chk("rst_ready", 128'(bus.ready), 128'(0));
    chk("rst_credits", 128'(bus.credits), 128'(0));
    chk("rst_drained", 128'(bus.drained), 128'(1));
    chk("rst_credit_error", 128'(bus.credit_error), 128'(0));
    chk("rst_cmd_out", 128'(bus.command_arbiter_out), 128'(idle_line()));
    repeat (2) @(negedge clock);
    rst = 1'b0;
    $display("cycle %0d reset released", cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_r;
    for (int i = 0; i < N; i++) begin
      lines[i]         = idle_line();
      lines[i].cmd     = 8'(8'h10 + i);
      lines[i].command = READ_CL_NA;
      lines[i].address = 64'h1000 * (i + 1);
      lines[i].size    = 12'd128;
    end

    //          en init req    resp rdy_rr rdy_fp cr dr src_rr src_fp
    tbl[0]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h0, 4'h0, 0, 1'b1, -1, -1};
    tbl[1]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h0, 4'h0, 0, 1'b0, -1, -1};
    tbl[2]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h1, 4'h1, 4, 1'b0, -1, -1};
    tbl[3]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h2, 4'h1, 3, 1'b0,  0,  0};
    tbl[4]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h4, 4'h1, 2, 1'b0,  1,  0};
    tbl[5]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h8, 4'h1, 1, 1'b0,  2,  0};
    tbl[6]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h0, 4'h0, 0, 1'b0,  3,  0};
    tbl[7]  = '{1'b1, 8'd4, 4'hF, 1'b0, 4'h0, 4'h0, 0, 1'b0, -1, -1};
    tbl[8]  = '{1'b1, 8'd4, 4'h3, 1'b1, 4'h0, 4'h0, 0, 1'b0, -1, -1};
    tbl[9]  = '{1'b1, 8'd4, 4'h3, 1'b0, 4'h1, 4'h1, 1, 1'b0, -1, -1};
    tbl[10] = '{1'b1, 8'd4, 4'h3, 1'b1, 4'h0, 4'h0, 0, 1'b0,  0,  0};
    tbl[11] = '{1'b1, 8'd4, 4'h3, 1'b1, 4'h2, 4'h1, 1, 1'b0, -1, -1};
    tbl[12] = '{1'b1, 8'd4, 4'h3, 1'b0, 4'h1, 4'h1, 1, 1'b0,  1,  0};
    tbl[13] = '{1'b1, 8'd4, 4'h0, 1'b0, 4'h0, 4'h0, 0, 1'b0,  0,  0};
    tbl[14] = '{1'b1, 8'd4, 4'h0, 1'b0, 4'h0, 4'h0, 0, 1'b0, -1, -1};

    do_reset();

    // Vector table: burst of four grants, then credit returns and a grant+response overlap.
    for (int i = 0; i < 15; i++) begin
      logic [3:0] rdy;
      int         src;
`ifdef CMD_SCHED_ROUND_ROBIN_EN
      rdy = tbl[i].rdy_rr;
      src = tbl[i].src_rr;
`else
      rdy = tbl[i].rdy_fp;
      src = tbl[i].src_fp;
`endif
      apply(tbl[i].en, tbl[i].init, tbl[i].req, tbl[i].resp);
      chk($sformatf("tbl%0d_ready", i), 128'(bus.ready), 128'(rdy));
      chk($sformatf("tbl%0d_credits", i), 128'(bus.credits), 128'(tbl[i].cr));
      chk($sformatf("tbl%0d_drained", i), 128'(bus.drained), 128'(tbl[i].dr));
      chk($sformatf("tbl%0d_cmd_out", i), 128'(bus.command_arbiter_out),
          128'((src < 0) ? idle_line() : issued(src)));
      tick();
    end

    // Drain after two grants with credit_init = 2.
    do_reset();
    apply(1'b1, 8'd2, 4'h1, 1'b0); tick();
    apply(1'b1, 8'd2, 4'h1, 1'b0); tick();
    apply(1'b1, 8'd2, 4'h1, 1'b0); tick();
    apply(1'b1, 8'd2, 4'h1, 1'b0); tick();
    apply(1'b0, 8'd2, 4'h1, 1'b0); tick();
    apply(1'b0, 8'd2, 4'h1, 1'b1);
    chk("drain_ready", 128'(bus.ready), 128'(0));
    chk("drain_drained", 128'(bus.drained), 128'(0));
    chk("drain_credits0", 128'(bus.credits), 128'(0));
    tick();
    apply(1'b0, 8'd2, 4'h1, 1'b1);
    chk("drain_credits1", 128'(bus.credits), 128'(1));
    tick();
    apply(1'b0, 8'd2, 4'h1, 1'b0);
    chk("drain_done", 128'(bus.drained), 128'(1));
    chk("drain_credits2", 128'(bus.credits), 128'(2));
    tick();
    apply(1'b0, 8'd2, 4'h1, 1'b0);
    chk("idle_drained", 128'(bus.drained), 128'(1));
    chk("idle_credits", 128'(bus.credits), 128'(0));
    chk("idle_ready", 128'(bus.ready), 128'(0));
    tick();

    // enabled_in falls in the same cycle as a grant: the grant still issues.
    do_reset();
    apply(1'b1, 8'd3, 4'h2, 1'b0); tick();
    apply(1'b1, 8'd3, 4'h2, 1'b0); tick();
    apply(1'b0, 8'd3, 4'h2, 1'b0);
    chk("fall_ready", 128'(bus.ready), 128'(4'h2));
    tick();
    apply(1'b0, 8'd3, 4'h2, 1'b0);
    chk("fall_ready_off", 128'(bus.ready), 128'(0));
    chk("fall_valid", 128'(bus.command_arbiter_out.valid), 128'(1));
    chk("fall_addr", 128'(bus.command_arbiter_out.address), 128'(lines[1].address));
    chk("fall_credits", 128'(bus.credits), 128'(2));
    tick();
    apply(1'b0, 8'd3, 4'h0, 1'b1); tick();
    apply(1'b0, 8'd3, 4'h0, 1'b0);
    chk("fall_drained", 128'(bus.drained), 128'(1));
    tick();

    // Spurious response at credits == limit is sticky until reset.
    do_reset();
    apply(1'b1, 8'd2, 4'h0, 1'b0); tick();
    apply(1'b1, 8'd2, 4'h0, 1'b0); tick();
    apply(1'b1, 8'd2, 4'h0, 1'b1); tick();
    apply(1'b1, 8'd2, 4'h0, 1'b0);
    chk("cerr_credits", 128'(bus.credits), 128'(2));
    chk("cerr_flag", 128'(bus.credit_error), 128'(1));
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 8'd2, 4'h5, 1'b0);
      chk("cerr_sticky", 128'(bus.credit_error), 128'(1));
      tick();
    end
    do_reset();

    // Response while IDLE is also an error.
    apply(1'b0, 8'd0, 4'h0, 1'b1); tick();
    apply(1'b0, 8'd0, 4'h0, 1'b0);
    chk("idle_resp_err", 128'(bus.credit_error), 128'(1));
    tick();

    // Asynchronous reset mid-RUN with one credit left and a pending grant.
    do_reset();
    apply(1'b1, 8'd1, 4'hF, 1'b0); tick();
    apply(1'b1, 8'd1, 4'hF, 1'b0); tick();
    apply(1'b1, 8'd1, 4'hF, 1'b0);
    chk("arst_pre_credits", 128'(bus.credits), 128'(1));
    chk("arst_pre_ready", 128'(bus.ready), 128'(4'h1));
    #2;
    do_reset();

    // Randomized traffic against the reference model.
    en_r = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [CW-1:0] init_r;
      logic [N-1:0]  req_r;
      logic          resp_r;
      if ($urandom_range(0, 99) == 0) do_reset();
      for (int i = 0; i < N; i++) lines[i] = rand_line();
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      init_r = CW'($urandom_range(0, 5));
      req_r  = N'($urandom);
      resp_r = (m_phase == M_RUN || m_phase == M_DRAIN) && (m_out > 0) &&
               ($urandom_range(0, 2) == 0);
      apply(en_r, init_r, req_r, resp_r);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/command_credit_scheduler.md
# command_credit_scheduler

Credit-aware round-robin scheduler that shares the single CAPI command port between NUM_REQUESTS command buffers. It sits between the per-engine command buffers and the PSL command interface. It issues at most one CommandBufferLine per cycle, and only while PSL command credits (ha_croom) remain. It tracks outstanding commands until their responses return and drains cleanly on disable.

## Interface
- NUM_REQUESTS, 4: number of requesting command buffers (2..16).
- CREDIT_WIDTH, 8: width of the credit counter; matches the ha_croom width.

- clock  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enabled_in  in  1  run request from the AFU control; level-sensitive.
- credit_init  in  CREDIT_WIDTH  PSL command room; sampled in LOAD only.
- response_valid  in  1  one PSL response received; returns one credit.
- command_buffer_in  in  NUM_REQUESTS x CommandBufferLine  head entry of each buffer.
- requests  in  NUM_REQUESTS  buffer i has a valid head entry.
- command_arbiter_out  out  CommandBufferLine  registered issued command.
- ready  out  NUM_REQUESTS  one-hot grant; buffer i pops its head this cycle.
- credits  out  CREDIT_WIDTH  current free credits.
- drained  out  1  all issued commands have completed; high in IDLE.
- credit_error  out  1  sticky: a credit was returned that was never issued.

## Operation
- FSM states:
  - IDLE: credits = 0. Goes to LOAD when enabled_in = 1.
  - LOAD: one cycle. credits <= credit_init and limit <= credit_init. Goes to RUN.
  - RUN: arbitration active. Goes to DRAIN when enabled_in = 0.
  - DRAIN: no grants. Goes to IDLE when credits == limit. Goes back to RUN if enabled_in returns high while credits < limit.
- Grant condition: state == RUN, credits != 0, and requests != 0. Otherwise ready = 0.
- Round-robin: the search starts at index ptr+1 mod NUM_REQUESTS. ptr <= granted index on each grant. ptr resets to NUM_REQUESTS-1, so index 0 wins first.
- ready is combinational from requests, ptr, state and credits. It is never asserted for a requester whose requests bit is low.
- Credit arithmetic, evaluated per cycle:
  - grant only: credits - 1.
  - response_valid only: credits + 1.
  - both: unchanged.
  - response_valid while credits == limit: credits holds and credit_error <= 1.
  - credits never underflows, because no grant is made at 0.
- response_valid is honoured in RUN and DRAIN. In IDLE and LOAD it is ignored and sets credit_error.
- command_arbiter_out: on a grant it registers command_buffer_in[granted] with valid = 1. On any other cycle it registers valid = 0, cmd = 0, command = INVALID, address = 0 and size = 0.
- drained = (state == IDLE) or (state == DRAIN and credits == limit).
- credit_error clears only on rst.

## Timing
- Reset values:
  - state IDLE, ptr NUM_REQUESTS-1, credits 0, limit 0.
  - command_arbiter_out all zero with valid 0 and command INVALID.
  - ready 0, drained 1, credit_error 0.
- Enable to first possible grant: enabled_in high in cycle t, LOAD in t+1, first ready in t+2.
- Grant to command: ready in cycle t, command_arbiter_out.valid in t+1. Issue latency is 1.
- Credit update takes effect the cycle after the grant or response. A grant taking the last credit blocks grants in the next cycle, unless response_valid arrives in the same cycle as that grant.
- Back-to-back grants are allowed every cycle while credits > 0, giving a sustained rate of 1 command per cycle.
- rst mid-operation returns to reset values immediately. Outstanding commands are forgotten.
- enabled_in falling in a cycle where ready is high: that grant completes, and the state is DRAIN from the next cycle.

## Configuration
- CMD_SCHED_ROUND_ROBIN_EN:
  - Defined: round-robin arbitration as above.
  - Undefined: fixed priority, with index 0 highest. ptr is not implemented and the credit and FSM behaviour is unchanged.

## Test plan
- Reset, enabled_in = 1, credit_init = 4, all 4 requests high for 8 cycles:
  - ready sequence is 0001, 0010, 0100, 1000, then 0000.
  - credits goes 4, 3, 2, 1, 0.
  - Outputs match each buffer's address, one cycle later.
- credits = 0, requests = 0011, response_valid pulse:
  - One cycle later credits = 1.
  - Next ready = the requester after the last granted one.
  - credits returns to 0.
- Simultaneous grant and response_valid with credits = 1: credits stays 1 and a grant occurs again the next cycle.
- credit_init = 2, two grants issued, enabled_in dropped:
  - state DRAIN, ready = 0, drained = 0.
  - After two response_valid pulses, drained = 1 and state IDLE.
- response_valid with credits == limit = 2: credits stays 2 and credit_error = 1 until rst.
- rst asserted mid-RUN with credits = 1: outputs return to reset values within the same cycle (asynchronous), and credits = 0.
